stack_ram_responder: RTL
========================

Name: stack_ram_responder

Overview:
- Memory-side responder for the CPU's start/done RAM protocol. It serves one read channel and one write channel against an on-chip single-port synchronous word RAM.
- Transfers 1..16 sixteen-bit words per request, one word per cycle, packed MSB-first in a 256-bit bus.
- Sits under the CPU core and serves stack load/store, register spill/fill and instruction fetch.

Parameters:
- ADDR_W, 12, RAM word-address width; depth = 2**ADDR_W words of 16 bits.
- MAX_WORDS, 16, maximum words per request; fixed at 256/16.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rd_start  in  1  read request level; held high by the initiator until rd_done is seen.
- rd_address  in  16  read start word address.
- rd_bytes  in  16  read length in bytes.
- rd_q  out  256  read data; word i at bits [255-16i -: 16].
- rd_done  out  1  one-cycle read-complete pulse.
- wr_start  in  1  write request level; held high until wr_done is seen.
- wr_address  in  16  write start word address.
- wr_bytes  in  16  write length in bytes.
- wr_data  in  256  write data, packed like rd_q.
- wr_done  out  1  one-cycle write-complete pulse.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE; rd_done=0, wr_done=0, busy=0, rd_q=0.
  - RAM contents are not cleared.
- Word count: N = min((bytes+1)>>1, 16), all arithmetic 16-bit. Examples: bytes=1 -> 1, bytes=3 -> 2, bytes=32 -> 16, bytes=64 -> 16.
- Address mapping: word i goes to RAM[(address+i) mod 2**ADDR_W]. Upper address bits are ignored and the address wraps silently at the top of the RAM.
- States: IDLE, WRITE, READ_ISSUE, READ_DRAIN, DONE, RELEASE.
- IDLE, at each edge:
  - If wr_start=1: latch wr_address, wr_data and N, then go to WRITE.
  - Else if rd_start=1: latch rd_address and N; clear the rd_q shadow to 0; go to READ_ISSUE.
  - Write has priority on simultaneous requests. A read still held high is accepted after the write completes and start is released.
  - Inputs are latched at accept. Later changes to address, bytes or data are ignored until the next accept.
- WRITE: one RAM write per cycle, words 0..N-1, with word index counter i. After the last word go to DONE.
- READ_ISSUE:
  - One RAM read address per cycle for i = 0..N-1.
  - RAM latency is 1 cycle; the returned word is stored into shadow slot i-1 the following cycle.
  - After the last issue go to READ_DRAIN, which captures the final word and then goes to DONE.
- DONE:
  - Pulse rd_done or wr_done for exactly 1 cycle.
  - For reads, rd_q updates from the shadow on the same edge that raises rd_done. Words N..15 are 0.
  - Go to RELEASE.
- RELEASE: wait until the start of the served channel is 0, then go to IDLE. This prevents one held request from being served twice.
- N=0 (bytes=0): go straight from accept to DONE with no RAM access; rd_q becomes all zero on a read.
- Latency, edges from accept to the done pulse:
  - Write: N+1.
  - Read: N+2.
  - bytes=0: 1.
- rd_q holds its value until the next read completes; a write never alters rd_q.
- Reset mid-transfer aborts the transfer and returns to IDLE with no done pulse. Words already written stay written.
- Read-after-write to the same address in a later request returns the new data; there is no intra-request hazard.

Decomposition:
- Shared package holds:
  - state enum (IDLE, WRITE, READ_ISSUE, READ_DRAIN, DONE, RELEASE);
  - constants WORD_W=16, BUS_W=256, MAX_WORDS=16;
  - a word-count function (bytes -> N with clamp).
- One sub-module: stack_ram_sp, a single-port synchronous RAM (ADDR_W, 16-bit, write-enable, registered read, no reset). The responder owns the FSM, counter, latches and packing.

Test Plan:
- Single word: write bytes=1, address=5, data[255:240]=0xBEEF, then read bytes=1 at address 5 -> wr_done 2 edges after accept; rd_done 3 edges after accept; rd_q[255:240]=0xBEEF and rd_q[239:0]=0.
- Burst: write bytes=32 at address 100 with words 0x0001..0x0010, then read bytes=32 at address 100 -> identical 256-bit pattern; rd_done 18 edges after accept.
- Odd length and wrap: write bytes=3 at address 4095 with words A/B -> RAM[4095]=A, RAM[0]=B; read bytes=4 at address 0xFFFF (maps to 4095) -> words A, B, rest 0.
- Simultaneous requests: rd_start and wr_start rise together at the same address -> write served first; read returns the new data; each done pulses exactly once; no double service while start is held through RELEASE.
- bytes=0 read -> rd_done 1 edge after accept, rd_q=0, no RAM access.
- Async reset mid 16-word write at word 7 -> outputs clear immediately; no wr_done; RAM words 0..6 written and 7..15 untouched; next request is served normally.

Source files
------------

// File: rtl/stack_ram_responder_pkg.sv
// Shared types and constants for the stack RAM responder: FSM states,
// bus geometry and the byte-length to word-count conversion.
package stack_ram_responder_pkg;

  localparam int WORD_W    = 16;
  localparam int BUS_W     = 256;
  localparam int MAX_WORDS = BUS_W / WORD_W;
  localparam int CNT_W     = $clog2(MAX_WORDS + 1);
  localparam int IDX_W     = $clog2(MAX_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ_ISSUE,
    READ_DRAIN,
    DONE,
    RELEASE
  } state_t;

  // Rounds bytes up to whole words in 16-bit arithmetic (0xFFFF wraps to 0 words)
  // and clamps to the bus capacity.
  function automatic logic [CNT_W-1:0] word_count(input logic [15:0] bytes);
    logic [15:0] half;
    half = (bytes + 16'd1) >> 1;
    if (half > 16'(MAX_WORDS))
      return CNT_W'(MAX_WORDS);
    return half[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/stack_ram_sp.sv
// Single-port synchronous word RAM with write enable and a registered
// read port (one cycle latency).
module stack_ram_sp #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the array has no reset so it maps onto block RAM; contents survive reset_n.
  always_ff @(posedge clock) begin
    if (we)
      mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/stack_ram_responder.sv
// Memory-side responder for the CPU start/done RAM protocol: serves one read
// and one write channel (write first) against a single-port word RAM.
module stack_ram_responder
  import stack_ram_responder_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             rd_start,
  input  logic [15:0]      rd_address,
  input  logic [15:0]      rd_bytes,
  output logic [BUS_W-1:0] rd_q,
  output logic             rd_done,
  input  logic             wr_start,
  input  logic [15:0]      wr_address,
  input  logic [15:0]      wr_bytes,
  input  logic [BUS_W-1:0] wr_data,
  output logic             wr_done,
  output logic             busy
);

  state_t             state, next_state;
  logic               is_write;
  logic [ADDR_W-1:0]  base_addr;
  logic [CNT_W-1:0]   n_words;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   cap_idx;
  logic               cap_valid;
  logic [BUS_W-1:0]   wr_buf;
  logic [WORD_W-1:0]  shadow [MAX_WORDS];

  logic [CNT_W-1:0]   wr_n, rd_n;
  logic               last_word;
  logic               ram_we;
  logic [ADDR_W-1:0]  ram_addr;
  logic [WORD_W-1:0]  ram_wdata, ram_rdata;
  logic               unused_addr_hi;

  assign wr_n      = word_count(wr_bytes);
  assign rd_n      = word_count(rd_bytes);
  assign last_word = ({1'b0, idx} == n_words - CNT_W'(1));

  // Address bits above the RAM depth are ignored; the address wraps silently.
  assign unused_addr_hi = ^{wr_address[15:ADDR_W], rd_address[15:ADDR_W]};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= next_state;
  end

  // NOTE: next_state defaults to state first so no path through the case infers a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (wr_start)
          next_state = (wr_n == '0) ? DONE : WRITE;
        else if (rd_start)
          next_state = (rd_n == '0) ? DONE : READ_ISSUE;
      end
      WRITE:      if (last_word) next_state = DONE;
      READ_ISSUE: if (last_word) next_state = READ_DRAIN;
      READ_DRAIN: next_state = DONE;
      DONE:       next_state = RELEASE;
      RELEASE: begin
        if (!(is_write ? wr_start : rd_start))
          next_state = IDLE;
      end
      default:    next_state = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    ram_we    = (state == WRITE);
    ram_addr  = base_addr + ADDR_W'(idx);
    ram_wdata = wr_buf[BUS_W-1 -: WORD_W];
  end

  // Datapath: request latches, word counter, read shadow and output packing.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      is_write  <= 1'b0;
      base_addr <= '0;
      n_words   <= '0;
      idx       <= '0;
      cap_idx   <= '0;
      cap_valid <= 1'b0;
      wr_buf    <= '0;
      rd_q      <= '0;
      rd_done   <= 1'b0;
      wr_done   <= 1'b0;
      for (int w = 0; w < MAX_WORDS; w++)
        shadow[w] <= '0;
    end else begin
      rd_done   <= (state == DONE) && !is_write;
      wr_done   <= (state == DONE) && is_write;
      // RAM data returns one cycle after its address, so capture lags issue by one.
      cap_valid <= (state == READ_ISSUE);
      cap_idx   <= idx;
      if (cap_valid)
        shadow[cap_idx] <= ram_rdata;

      case (state)
        IDLE: begin
          idx <= '0;
          if (wr_start) begin
            is_write  <= 1'b1;
            base_addr <= wr_address[ADDR_W-1:0];
            n_words   <= wr_n;
            wr_buf    <= wr_data;
          end else if (rd_start) begin
            is_write  <= 1'b0;
            base_addr <= rd_address[ADDR_W-1:0];
            n_words   <= rd_n;
            for (int w = 0; w < MAX_WORDS; w++)
              shadow[w] <= '0;
          end
        end
        WRITE: begin
          idx    <= idx + IDX_W'(1);
          wr_buf <= wr_buf << WORD_W;
        end
        READ_ISSUE: idx <= idx + IDX_W'(1);
        DONE: begin
          if (!is_write)
            for (int w = 0; w < MAX_WORDS; w++)
              rd_q[BUS_W-1-WORD_W*w -: WORD_W] <= shadow[w];
        end
        default: ;
      endcase
    end
  end

  stack_ram_sp #(
    .ADDR_W (ADDR_W),
    .DATA_W (WORD_W)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule
